uart_mem_loader: RTL and testbench



---
 rtl/uart_mem_loader.sv | 207 ++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// UART receive-file to memory loader: parses ASCII-hex words into imem/dmem.
// Optional LOADER_CHECKSUM_EN keeps a wrapping sum of the words written.
module uart_mem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_ready,
  input  logic [7:0]        reg_addr,
  input  logic [7:0]        reg_pointer,
  input  logic [7:0]        fifo_dout,
  input  logic              fifo_rdy,
  output logic              fifo_re,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_WORDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SOT  = 3'd1;
  localparam logic [2:0] S_COL  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]        state;
  logic              tgt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       word;
  logic [3:0]        dcnt;
  logic              eof_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              err_q;
  logic [CW-1:0]     wcnt;

  logic       hex_ok;
  logic [3:0] nib;
  logic       is_delim;
  logic       is_eof;
  logic       is_sot;
  logic       pop;
  logic       arm;
  logic       full;
  logic       wr_en;

  always_comb begin
    hex_ok = 1'b1;
    nib    = 4'd0;
    unique case (1'b1)
      (fifo_dout >= 8'h30 && fifo_dout <= 8'h39):
        nib = fifo_dout[3:0];
      (fifo_dout >= 8'h41 && fifo_dout <= 8'h46),
      (fifo_dout >= 8'h61 && fifo_dout <= 8'h66):
        nib = fifo_dout[3:0] + 4'd9;
      default:
        hex_ok = 1'b0;
    endcase
  end

  assign is_delim = (fifo_dout == 8'h0d) || (fifo_dout == 8'h0a);
  assign is_eof   = (fifo_dout == 8'h04);
  assign is_sot   = (fifo_dout == 8'h02);

  assign pop  = fifo_rdy && (state == S_SOT || state == S_COL);
  assign arm  = reg_ready &&
                (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign full = (wcnt == MAXC);
  assign wr_en = (state == S_WR) && !full;

  // Strobes are masked by reset so a reset landing on WRITE never writes.
  assign fifo_re    = pop;
  assign imem_we    = wr_en && !tgt && !reset;
  assign dmem_we    = wr_en && tgt && !reset;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state == S_SOT) || (state == S_COL) || (state == S_WR);
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = wcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tgt     <= 1'b0;
      base    <= '0;
      word    <= '0;
      dcnt    <= '0;
      eof_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wcnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (reg_ready) begin
            tgt    <= reg_addr[0];
            base   <= ADDR_W'(reg_pointer);
            wcnt   <= '0;
            done_q <= 1'b0;
            dcnt   <= '0;
            word   <= '0;
            eof_q  <= 1'b0;
            if (reg_addr > 8'h01) begin
              err_q <= 1'b1;
              state <= S_ERR;
            end else begin
              err_q <= 1'b0;
              state <= S_SOT;
            end
          end
        end
        S_SOT: begin
          if (pop) begin
            if (is_sot) begin
              state <= S_COL;
            end else if (is_eof) begin
              err_q <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_COL: begin
          if (pop) begin
            if (hex_ok) begin
              if (dcnt == 4'd8) begin
                err_q <= 1'b1;
              end else begin
                word <= {word[27:0], nib};
                dcnt <= dcnt + 4'd1;
              end
            end else if (is_delim || is_eof) begin
              if (dcnt == 4'd8) begin
                // Address/data are latched here so they are valid in WRITE.
                if (!full) begin
                  addr_q  <= base + wcnt[ADDR_W-1:0];
                  wdata_q <= word;
                end
                eof_q <= is_eof;
                state <= S_WR;
              end else if (dcnt != 4'd0) begin
                err_q <= 1'b1;
                dcnt  <= '0;
                word  <= '0;
                if (is_eof) state <= S_ERR;
              end else if (is_eof) begin
                done_q <= !err_q;
                state  <= S_DONE;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_WR: begin
          dcnt <= '0;
          if (full) begin
            err_q <= 1'b1;
            state <= S_ERR;
          end else begin
            wcnt <= wcnt + ONE;
            if (eof_q) begin
              done_q <= !err_q;
              state  <= S_DONE;
            end else begin
              state <= S_COL;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (arm) begin
      csum <= '0;
    end else if (wr_en) begin
      csum <= csum + wdata_q;
    end
  end

  assign checksum = csum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: stream-level reference model, random loads.
`timescale 1ns/1ps
module tb_uart_mem_loader;

  typedef struct {
    bit          tgt;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rr = '0;
  logic [7:0] ra = '0;
  logic [7:0] rp = '0;
  logic [7:0] fd = '0;
  logic [1:0] fr = '0;
  logic [1:0] fre, iwe, dwe, bsy, ldn, ler;
  logic [7:0]  maddr [2];
  logic [31:0] mwd [2];
  logic [8:0]  wc [2];
  logic [31:0] cs [2];

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;
  bit stall = 1'b0;
  bit phase = 1'b0;
  logic [7:0] fq[$];
  logic [7:0] stim[$];
  wr_t exp_q[$];
  wr_t log_q[$];
  wr_t ref_q[$];
  bit exp_err, exp_done;
  int exp_cnt, exp_pops;
  logic [31:0] exp_sum;
  int pops = 0;
  bit pop_flag = 1'b0;
  bit prev_pop = 1'b0;

  always #5 clk = ~clk;

  uart_mem_loader #(.ADDR_W(8), .MAX_WORDS(256)) u0 (
    .clk(clk), .reset(reset), .reg_ready(rr[0]), .reg_addr(ra),
    .reg_pointer(rp), .fifo_dout(fd), .fifo_rdy(fr[0]), .fifo_re(fre[0]),
    .imem_we(iwe[0]), .dmem_we(dwe[0]), .mem_addr(maddr[0]),
    .mem_wdata(mwd[0]), .busy(bsy[0]), .load_done(ldn[0]),
    .load_err(ler[0]), .word_count(wc[0]), .checksum(cs[0]));

  uart_mem_loader #(.ADDR_W(8), .MAX_WORDS(2)) u1 (
    .clk(clk), .reset(reset), .reg_ready(rr[1]), .reg_addr(ra),
    .reg_pointer(rp), .fifo_dout(fd), .fifo_rdy(fr[1]), .fifo_re(fre[1]),
    .imem_we(iwe[1]), .dmem_we(dwe[1]), .mem_addr(maddr[1]),
    .mem_wdata(mwd[1]), .busy(bsy[1]), .load_done(ldn[1]),
    .load_err(ler[1]), .word_count(wc[1]), .checksum(cs[1]));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexchar(input int v, input bit up);
    if (v < 10) return 8'(48 + v);
    return up ? 8'(55 + v) : 8'(87 + v);
  endfunction

  task automatic push_b(input logic [7:0] b);
    stim.push_back(b);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  // Reference: walk the character stream once, per the loader's rules.
  task automatic model(input logic [7:0] t, input logic [7:0] p,
                       input int maxw);
    int n, cnt, ph, used, v;
    logic [31:0] w, sum;
    bit err, done, stop;
    logic [7:0] c;
    wr_t e;
    n = 0; cnt = 0; ph = 0; used = 0;
    w = 0; sum = 0; err = 0; done = 0; stop = 0;
    exp_q.delete();
    if (t > 8'h01) begin err = 1; stop = 1; end
    for (int i = 0; i < stim.size(); i++) begin
      if (stop) break;
      c = stim[i];
      used = i + 1;
      v = hexval(c);
      if (ph == 0) begin
        if (c == 8'h02) ph = 1;
        else if (c == 8'h04) begin err = 1; stop = 1; end
      end else if (v >= 0) begin
        if (cnt == 8) err = 1;
        else begin w = (w << 4) | 32'(v); cnt++; end
      end else if (c == 8'h0d || c == 8'h0a || c == 8'h04) begin
        if (cnt == 8) begin
          if (n == maxw) begin
            err = 1; stop = 1;
          end else begin
            e.tgt = t[0];
            e.addr = 8'(int'(p) + n);
            e.data = w;
            exp_q.push_back(e);
            sum = sum + w;
            n++;
            if (c == 8'h04) begin done = !err; stop = 1; end
          end
        end else if (cnt > 0) begin
          err = 1;
          if (c == 8'h04) stop = 1;
        end else if (c == 8'h04) begin
          done = !err; stop = 1;
        end
        cnt = 0; w = 0;
      end else begin
        err = 1;
      end
    end
    exp_err = err; exp_done = done; exp_cnt = n;
    exp_sum = sum; exp_pops = used;
  endtask

  always @(negedge clk) begin
    wr_t e;
    for (int k = 0; k < 2; k++)
      chk("re_without_rdy", 64'(fre[k] & ~fr[k]), 64'(0));
    chk("idle_inst_write", 64'(iwe[1-sel] | dwe[1-sel]), 64'(0));
    if (iwe[sel] | dwe[sel]) begin
      chk("both_strobes", 64'(iwe[sel] & dwe[sel]), 64'(0));
      chk("write_latency", 64'(prev_pop), 64'(1));
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write at %0t: addr %0h data %0h",
                 $time, maddr[sel], mwd[sel]);
      end else begin
        e = exp_q.pop_front();
        chk("wr_target", 64'(dwe[sel]), 64'(e.tgt));
        chk("wr_addr", 64'(maddr[sel]), 64'(e.addr));
        chk("wr_data", 64'(mwd[sel]), 64'(e.data));
      end
      e.tgt = dwe[sel];
      e.addr = maddr[sel];
      e.data = mwd[sel];
      log_q.push_back(e);
    end
    pop_flag = fre[sel] & fr[sel];
    prev_pop = pop_flag;
  end

  always @(posedge clk) begin
    #2;
    if (pop_flag && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    pop_flag = 1'b0;
    phase = ~phase;
    fd = (fq.size() > 0) ? fq[0] : 8'h00;
    fr = '0;
    if (fq.size() > 0 && (!stall || phase)) fr[sel] = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int s, input logic [7:0] t,
                          input logic [7:0] p, input bit st);
    int guard;
    logic [31:0] xs;
    sel = s;
    stall = st;
    fq.delete();
    foreach (stim[i]) fq.push_back(stim[i]);
    model(t, p, (s == 0) ? 256 : 2);
    log_q.delete();
    tick(1);
    pops = 0;
    ra = t;
    rp = p;
    rr[s] = 1'b1;
    tick(1);
    rr = '0;
    @(negedge clk);
    chk("arm_word_count", 64'(wc[s]), 64'(0));
    chk("arm_done", 64'(ldn[s]), 64'(0));
    chk("arm_err", 64'(ler[s]), 64'(t > 8'h01));
    chk("arm_checksum", 64'(cs[s]), 64'(0));
    guard = 0;
    while (bsy[s] && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: still busy after %0d cycles", guard);
    end
    repeat (2) @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    xs = exp_sum;
`else
    xs = 32'd0;
`endif
    chk("missing_writes", 64'(exp_q.size()), 64'(0));
    chk("word_count", 64'(wc[s]), 64'(exp_cnt));
    chk("load_done", 64'(ldn[s]), 64'(exp_done));
    chk("load_err", 64'(ler[s]), 64'(exp_err));
    chk("checksum", 64'(cs[s]), 64'(xs));
    chk("fifo_pops", 64'(pops), 64'(exp_pops));
  endtask

  task automatic build_random(input int nw, input bit inj);
    logic [31:0] w;
    int nd, nl;
    stim.delete();
    if ($urandom_range(3) == 0) push_str("zz");
    push_b(8'h02);
    for (int k = 0; k < nw; k++) begin
      w = $urandom;
      nd = 8;
      if (inj && $urandom_range(5) == 0) nd = 1 + $urandom_range(6);
      if (inj && $urandom_range(7) == 0) nd = 9;
      for (int d = 0; d < nd; d++) begin
        if (d < 8) push_b(hexchar(int'(w[31-4*d -: 4]), $urandom_range(1) == 1));
        else push_b(hexchar($urandom_range(15), 1'b1));
      end
      if (inj && $urandom_range(9) == 0) push_str("G");
      if (!(k == nw - 1 && $urandom_range(2) == 0)) begin
        nl = 1 + $urandom_range(2);
        for (int j = 0; j < nl; j++)
          push_b($urandom_range(1) == 1 ? 8'h0d : 8'h0a);
      end
    end
    push_b(8'h04);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t;
    reset = 1'b1;
    tick(3);
    for (int k = 0; k < 2; k++) begin
      chk("rst_fifo_re", 64'(fre[k]), 64'(0));
      chk("rst_strobes", 64'(iwe[k] | dwe[k]), 64'(0));
      chk("rst_addr", 64'(maddr[k]), 64'(0));
      chk("rst_wdata", 64'(mwd[k]), 64'(0));
      chk("rst_flags", 64'({bsy[k], ldn[k], ler[k]}), 64'(0));
      chk("rst_count", 64'(wc[k]), 64'(0));
      chk("rst_checksum", 64'(cs[k]), 64'(0));
    end
    reset = 1'b0;
    tick(2);

    stim.delete();
    push_b(8'h02); push_str("DEADBEEF"); push_b(8'h0d); push_b(8'h0a);
    push_str("0000002a"); push_b(8'h0a); push_b(8'h04);
    run_load(0, 8'h00, 8'h10, 1'b0);
    chk("t1_nwrites", 64'(log_q.size()), 64'(2));
    if (log_q.size() >= 2) begin
      chk("t1_tgt0", 64'(log_q[0].tgt), 64'(0));
      chk("t1_addr0", 64'(log_q[0].addr), 64'(8'h10));
      chk("t1_data0", 64'(log_q[0].data), 64'(32'hDEADBEEF));
      chk("t1_addr1", 64'(log_q[1].addr), 64'(8'h11));
      chk("t1_data1", 64'(log_q[1].data), 64'(32'h0000002A));
    end
    chk("t1_count", 64'(wc[0]), 64'(2));
    chk("t1_done", 64'({ldn[0], ler[0]}), 64'(2'b10));
`ifdef LOADER_CHECKSUM_EN
    chk("t1_checksum", 64'(cs[0]), 64'(32'hDEADBF19));
`endif

    stim.delete();
    push_b(8'h02); push_str("12345678"); push_b(8'h04);
    run_load(0, 8'h01, 8'hFF, 1'b0);
    chk("t2_nwrites", 64'(log_q.size()), 64'(1));
    if (log_q.size() >= 1) begin
      chk("t2_tgt", 64'(log_q[0].tgt), 64'(1));
      chk("t2_addr", 64'(log_q[0].addr), 64'(8'hFF));
      chk("t2_data", 64'(log_q[0].data), 64'(32'h12345678));
    end
    chk("t2_done", 64'(ldn[0]), 64'(1));

    stim.delete();
    push_b(8'h02); push_str("12G4"); push_b(8'h0a);
    push_str("abc"); push_b(8'h0a); push_b(8'h04);
    run_load(0, 8'h00, 8'h00, 1'b0);
    chk("t3_nwrites", 64'(log_q.size()), 64'(0));
    chk("t3_flags", 64'({ldn[0], ler[0]}), 64'(2'b01));

    stim.delete();
    push_b(8'h02); push_str("11111111"); push_b(8'h0a); push_b(8'h04);
    run_load(0, 8'h05, 8'h00, 1'b0);
    chk("t4_err", 64'(ler[0]), 64'(1));
    chk("t4_pops", 64'(pops), 64'(0));

    stim.delete();
    push_b(8'h02); push_str("0badc0de"); push_b(8'h0a);
    push_str("11223344"); push_b(8'h0d); push_b(8'h0a);
    push_str("CAFEf00d"); push_b(8'h0a); push_b(8'h04);
    run_load(0, 8'h00, 8'h20, 1'b0);
    ref_q = log_q;
    run_load(0, 8'h00, 8'h20, 1'b1);
    chk("t5_nwrites", 64'(log_q.size()), 64'(3));
    chk("t5_same_n", 64'(log_q.size()), 64'(ref_q.size()));
    for (int i = 0; i < log_q.size() && i < ref_q.size(); i++) begin
      chk("t5_same_addr", 64'(log_q[i].addr), 64'(ref_q[i].addr));
      chk("t5_same_data", 64'(log_q[i].data), 64'(ref_q[i].data));
    end

    stim.delete();
    push_b(8'h02); push_str("00000001"); push_b(8'h0a);
    push_str("00000002"); push_b(8'h0a);
    push_str("00000003"); push_b(8'h0a); push_b(8'h04);
    run_load(1, 8'h01, 8'hFF, 1'b0);
    chk("t6_nwrites", 64'(log_q.size()), 64'(2));
    if (log_q.size() >= 2)
      chk("t6_wrap_addr", 64'(log_q[1].addr), 64'(8'h00));
    chk("t6_flags", 64'({ldn[1], ler[1]}), 64'(2'b01));
    chk("t6_count", 64'(wc[1]), 64'(2));

    sel = 0;
    stall = 1'b0;
    stim.delete();
    push_b(8'h02); push_str("1234");
    fq.delete();
    foreach (stim[i]) fq.push_back(stim[i]);
    exp_q.delete();
    tick(1);
    ra = 8'h00; rp = 8'h40; rr[0] = 1'b1;
    tick(1);
    rr = '0;
    tick(10);
    chk("t7_busy_before", 64'(bsy[0]), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("t7_strobe_in_reset", 64'(iwe[0] | dwe[0]), 64'(0));
    tick(1);
    @(negedge clk);
    chk("t7_flags", 64'({bsy[0], ldn[0], ler[0], iwe[0], dwe[0]}), 64'(0));
    chk("t7_addr", 64'(maddr[0]), 64'(0));
    chk("t7_wdata", 64'(mwd[0]), 64'(0));
    chk("t7_count", 64'(wc[0]), 64'(0));
    chk("t7_checksum", 64'(cs[0]), 64'(0));
    tick(1);
    reset = 1'b0;
    fq.delete();
    tick(2);

    for (int r = 0; r < 30; r++) begin
      build_random(1 + $urandom_range(5), $urandom_range(2) == 0);
      t = ($urandom_range(9) == 0) ? 8'(2 + $urandom_range(250))
                                   : 8'($urandom_range(1));
      run_load((r % 5 == 4) ? 1 : 0, t, 8'($urandom_range(255)),
               $urandom_range(1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
